// File: rtl/spi_slave_if_pkg.sv
// spi_slave_if_pkg: shared defaults, SPI mode encodings and FSM states for the SPI responder
package spi_slave_if_pkg;

    localparam int SPI_SLAVE_CHAR_LEN    = 8;
    localparam int SPI_SLAVE_SYNC_STAGES = 2;

    localparam logic [1:0] SPI_SLAVE_MODE0 = 2'd0;
    localparam logic [1:0] SPI_SLAVE_MODE1 = 2'd1;
    localparam logic [1:0] SPI_SLAVE_MODE2 = 2'd2;
    localparam logic [1:0] SPI_SLAVE_MODE3 = 2'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: pad synchronizers for SCLK/SS/MOSI plus registered SCLK rise/fall pulses
module spi_slave_sync
    import spi_slave_if_pkg::*;
#(
    parameter int   STAGES    = SPI_SLAVE_SYNC_STAGES,
    parameter logic SCLK_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic ss_o,
    output logic mosi_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
    logic              sclk_prev_q, sclk_prev_d, rise_q, rise_d, fall_q, fall_d;

    // shift every pad through its chain and compare synchronized SCLK with its previous value
    always_comb begin
        sclk_d      = {sclk_q[STAGES-2:0], sclk_i};
        ss_d        = {ss_q[STAGES-2:0], ss_i};
        mosi_d      = {mosi_q[STAGES-2:0], mosi_i};
        sclk_prev_d = sclk_q[STAGES-1];
        rise_d      = sclk_q[STAGES-1] && !sclk_prev_q;
        fall_d      = !sclk_q[STAGES-1] && sclk_prev_q;
    end

    // SCLK resets to its idle level and SS to deselected so leaving reset creates no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= {STAGES{SCLK_IDLE}};
            ss_q        <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= SCLK_IDLE;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            sclk_prev_q <= sclk_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign ss_o   = ss_q[STAGES-1];
    assign mosi_o = mosi_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI responder with oversampled pads, 1-entry TX buffer, RX register and sticky errors
// Optional macro SPI_SLAVE_LSB_EN adds lsb_i to select LSB-first shifting per selection.
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int CHAR_LEN    = SPI_SLAVE_CHAR_LEN,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = SPI_SLAVE_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk_pad_i,
    input  logic                ss_pad_i,
    input  logic                mosi_pad_i,
    output logic                miso_pad_o,
    output logic                miso_oe_o,
    input  logic [CHAR_LEN-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [CHAR_LEN-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                overrun_o,
    output logic                underrun_o,
`ifdef SPI_SLAVE_LSB_EN
    input  logic                clr_err_i,
    input  logic                lsb_i
`else
    input  logic                clr_err_i
`endif
);

    localparam int   CNT_W       = $clog2(CHAR_LEN);
    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic                ss_s, mosi_s, sclk_rise, sclk_fall;
    logic                sample, start, stop, shift, last, load, accept, rx_take;
    logic [CHAR_LEN-1:0] rx_next;
    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CHAR_LEN-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [CHAR_LEN-1:0] tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
    logic                tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
    logic                overrun_q, overrun_d, underrun_q, underrun_d, lsb_q, lsb_d;

    spi_slave_sync #(
        .STAGES    (SYNC_STAGES),
        .SCLK_IDLE (CPOL != 0)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sclk_i (sclk_pad_i),
        .ss_i   (ss_pad_i),
        .mosi_i (mosi_pad_i),
        .ss_o   (ss_s),
        .mosi_o (mosi_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // per-cycle strobes: selection changes, sample edges, character completion, buffer handshakes
    always_comb begin
        sample  = SAMPLE_RISE ? sclk_rise : sclk_fall;
        start   = (state_q == ST_IDLE) && !ss_s;
        stop    = (state_q == ST_ACTIVE) && ss_s;
        shift   = (state_q == ST_ACTIVE) && !ss_s && sample;
        last    = shift && (bit_cnt_q == CNT_W'(CHAR_LEN - 1));
        load    = start || last;
        accept  = tx_valid_i && !tx_full_q;
        rx_take = last && (!rx_valid_q || rx_ready_i);
        rx_next = lsb_q ? {mosi_s, rx_shift_q[CHAR_LEN-1:1]} : {rx_shift_q[CHAR_LEN-2:0], mosi_s};
    end

    // next state; a load sees the buffer as it was this cycle, so a same-cycle accept still underruns
    always_comb begin
        state_d    = start ? ST_ACTIVE : stop ? ST_IDLE : state_q;
        bit_cnt_d  = (load || stop) ? '0 : shift ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
        tx_shift_d = load ? (tx_full_q ? tx_buf_q : '0)
                   : shift ? (lsb_q ? tx_shift_q >> 1 : tx_shift_q << 1) : tx_shift_q;
        rx_shift_d = (load || stop) ? '0 : shift ? rx_next : rx_shift_q;
        tx_buf_d   = accept ? tx_data_i : tx_buf_q;
        tx_full_d  = accept || (tx_full_q && !load);
        rx_data_d  = rx_take ? rx_next : rx_data_q;
        rx_valid_d = rx_take || (rx_valid_q && !rx_ready_i);
        overrun_d  = (last && rx_valid_q && !rx_ready_i) || (overrun_q && !clr_err_i);
        underrun_d = (load && !tx_full_q) || (underrun_q && !clr_err_i);
`ifdef SPI_SLAVE_LSB_EN
        lsb_d      = start ? lsb_i : lsb_q;
`else
        lsb_d      = 1'b0;
`endif
    end

    // state registers; reset aborts any character in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            lsb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            lsb_q      <= lsb_d;
        end
    end

    assign miso_oe_o  = (state_q == ST_ACTIVE);
    assign miso_pad_o = miso_oe_o && (lsb_q ? tx_shift_q[0] : tx_shift_q[CHAR_LEN-1]);
    assign tx_ready_o = !tx_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign overrun_o  = overrun_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: one responder per SPI mode driven by a bit-banged master, checked against a transaction model
module tb_spi_slave_if;

    localparam int CL = 8;
    localparam int S  = 2;
    localparam int H  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          sclk [4], ss [4], mosi [4], miso [4], oe [4];
    logic          tx_valid [4], tx_ready [4], rx_valid [4], rx_ready [4];
    logic          ovr [4], und [4], clr [4];
    logic [CL-1:0] tx_data [4], rx_data [4];
`ifdef SPI_SLAVE_LSB_EN
    logic          lsb [4];
`endif

    bit            m_full [4], m_rxv [4], m_ovr [4], m_und [4], m_lsb [4];
    logic [CL-1:0] m_buf [4], m_cur [4], m_rxd [4];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            spi_slave_if #(
                .CHAR_LEN    (CL),
                .CPOL        (g / 2),
                .CPHA        (g % 2),
                .SYNC_STAGES (S)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .sclk_pad_i (sclk[g]),
                .ss_pad_i   (ss[g]),
                .mosi_pad_i (mosi[g]),
                .miso_pad_o (miso[g]),
                .miso_oe_o  (oe[g]),
                .tx_data_i  (tx_data[g]),
                .tx_valid_i (tx_valid[g]),
                .tx_ready_o (tx_ready[g]),
                .rx_data_o  (rx_data[g]),
                .rx_valid_o (rx_valid[g]),
                .rx_ready_i (rx_ready[g]),
                .overrun_o  (ovr[g]),
                .underrun_o (und[g]),
`ifdef SPI_SLAVE_LSB_EN
                .clr_err_i  (clr[g]),
                .lsb_i      (lsb[g])
`else
                .clr_err_i  (clr[g])
`endif
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 4; m++) begin
            m_full[m] = 0; m_rxv[m] = 0; m_ovr[m] = 0; m_und[m] = 0; m_lsb[m] = 0;
            m_buf[m] = '0; m_cur[m] = '0; m_rxd[m] = '0;
        end
    endfunction

    // the responder starts every character with the buffered value, or zeros with an underrun
    function automatic void model_load(input int m);
        if (m_full[m]) begin
            m_cur[m]  = m_buf[m];
            m_full[m] = 0;
        end else begin
            m_cur[m] = '0;
            m_und[m] = 1;
        end
    endfunction

    task automatic hwait(input int m, input int act);
        if (act == 0) begin
            repeat (H) @(negedge clk);
        end else begin
            repeat (S + 1) @(negedge clk);
            if (act == 1) chk("rx_valid_early", rx_valid[m], 0);
            else rx_ready[m] = 1'b1;
            @(negedge clk);
            if (act == 1) chk("rx_valid_latency", rx_valid[m], 1);
            else rx_ready[m] = 1'b0;
            repeat (H - S - 2) @(negedge clk);
        end
    endtask

    task automatic xfer(input int m, input logic [CL-1:0] d, input int nbits, input int act,
                        output logic [CL-1:0] q);
        bit cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2) == 1;
        q = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            int a;
            b = m_lsb[m] ? i : CL - 1 - i;
            a = (i == nbits - 1) ? act : 0;
            if (!cpha) begin
                mosi[m] = d[b];
                hwait(m, 0);
                sclk[m] = ~cpol;
                q[b] = miso[m];
                hwait(m, a);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = d[b];
                hwait(m, 0);
                sclk[m] = cpol;
                q[b] = miso[m];
                hwait(m, a);
            end
        end
    endtask

    task automatic send_char(input int m, input logic [CL-1:0] d, input int act);
        logic [CL-1:0] q, exp;
        exp = m_cur[m];
        xfer(m, d, CL, act, q);
        chk("miso_char", q, exp);
        if (!m_rxv[m] || act == 2) begin
            m_rxd[m] = d;
            m_rxv[m] = 1;
        end else begin
            m_ovr[m] = 1;
        end
        model_load(m);
    endtask

    task automatic push(input int m, input logic [CL-1:0] d);
        chk("tx_ready", tx_ready[m], !m_full[m]);
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        if (!m_full[m]) begin
            m_full[m] = 1;
            m_buf[m]  = d;
        end
    endtask

    task automatic sel(input int m, input bit l);
        m_lsb[m] = l;
`ifdef SPI_SLAVE_LSB_EN
        lsb[m] = l;
`endif
        ss[m] = 1'b0;
        model_load(m);
        repeat (2 * H) @(negedge clk);
        chk("oe_selected", oe[m], 1);
        chk("underrun_at_select", und[m], m_und[m]);
    endtask

    task automatic desel(input int m);
        repeat (H) @(negedge clk);
        ss[m] = 1'b1;
        repeat (2 * H) @(negedge clk);
        chk("oe_idle", oe[m], 0);
        chk("miso_idle", miso[m], 0);
        chk("rx_valid_idle", rx_valid[m], m_rxv[m]);
        chk("overrun", ovr[m], m_ovr[m]);
        chk("underrun", und[m], m_und[m]);
        chk("tx_ready_idle", tx_ready[m], !m_full[m]);
    endtask

    task automatic consume(input int m);
        chk("rx_valid", rx_valid[m], m_rxv[m]);
        chk("rx_data", rx_data[m], m_rxd[m]);
        rx_ready[m] = 1'b1;
        @(negedge clk);
        rx_ready[m] = 1'b0;
        m_rxv[m] = 0;
        chk("rx_valid_cleared", rx_valid[m], 0);
    endtask

    task automatic clr_err(input int m);
        clr[m] = 1'b1;
        @(negedge clk);
        clr[m] = 1'b0;
        m_ovr[m] = 0;
        m_und[m] = 0;
        chk("overrun_cleared", ovr[m], 0);
        chk("underrun_cleared", und[m], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [CL-1:0] q;
        int m, n;
        for (int i = 0; i < 4; i++) begin
            sclk[i] = (i >= 2); ss[i] = 1'b1; mosi[i] = 1'b0;
            tx_valid[i] = 1'b0; tx_data[i] = '0; rx_ready[i] = 1'b0; clr[i] = 1'b0;
`ifdef SPI_SLAVE_LSB_EN
            lsb[i] = 1'b0;
`endif
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_tx_ready", tx_ready[i], 1);
            chk("reset_rx_valid", rx_valid[i], 0);
            chk("reset_rx_data", rx_data[i], 0);
            chk("reset_miso", miso[i], 0);
            chk("reset_oe", oe[i], 0);
            chk("reset_flags", {ovr[i], und[i]}, 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        push(0, 8'h3C);
        sel(0, 0);
        send_char(0, 8'hA5, 1);
        consume(0);
        desel(0);
        clr_err(0);

        push(0, 8'h11);
        sel(0, 0);
        push(0, 8'h22);
        send_char(0, 8'h01, 0);
        consume(0);
        send_char(0, 8'h02, 0);
        consume(0);
        desel(0);
        clr_err(0);

        sel(0, 0);
        send_char(0, 8'h96, 0);
        consume(0);
        desel(0);
        clr_err(0);

        sel(0, 0);
        send_char(0, 8'h55, 0);
        send_char(0, 8'hAA, 0);
        desel(0);
        consume(0);
        clr_err(0);
        sel(0, 0);
        send_char(0, 8'h55, 0);
        send_char(0, 8'hAA, 2);
        desel(0);
        consume(0);
        clr_err(0);

        push(0, 8'h6E);
        sel(0, 0);
        xfer(0, 8'hFF, 5, 0, q);
        desel(0);
        sel(0, 0);
        send_char(0, 8'h5A, 0);
        consume(0);
        desel(0);
        clr_err(0);

        for (int i = 1; i < 4; i++) begin
            push(i, 8'hC3);
            sel(i, 0);
            send_char(i, 8'hC3, 1);
            consume(i);
            desel(i);
            clr_err(i);
        end

`ifdef SPI_SLAVE_LSB_EN
        push(0, 8'h01);
        sel(0, 1);
        send_char(0, 8'h01, 0);
        consume(0);
        desel(0);
        clr_err(0);
`endif

        for (int it = 0; it < 20; it++) begin
            m = $urandom_range(3);
            n = $urandom_range(1, 3);
            if ($urandom_range(1) == 1) push(m, CL'($urandom));
            sel(m, 0);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(1) == 1) push(m, CL'($urandom));
                send_char(m, CL'($urandom), ($urandom_range(1) == 1) ? 2 : 0);
                if ($urandom_range(1) == 1 && m_rxv[m]) consume(m);
            end
            desel(m);
            if (m_rxv[m]) consume(m);
            clr_err(m);
        end

        push(0, 8'h77);
        sel(0, 0);
        xfer(0, 8'hC5, 5, 0, q);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rx_valid", rx_valid[0], 0);
        chk("abort_oe", oe[0], 0);
        chk("abort_tx_ready", tx_ready[0], 1);
        chk("abort_underrun", und[0], 0);
        ss[0] = 1'b1;
        sclk[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
